// File: rtl/gci_std_display_fill_engine.sv
// Rectangle fill engine for the display controller's VRAM write port.
// Latches a rectangle on iSTART, clips it to the screen, then issues one
// pixel write per accepted cycle in row-major order. The row base address is
// updated by adding the pitch, so the only multiply is in the one-cycle SETUP.
module gci_std_display_fill_engine #(
    parameter int          P_H_WIDTH   = 640,
    parameter int          P_V_HEIGHT  = 480,
    parameter logic [31:0] P_ADDR_BASE = 32'h0
)(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iSTART,
    input  logic [9:0]  iX,
    input  logic [9:0]  iY,
    input  logic [10:0] iWIDTH,
    input  logic [9:0]  iHEIGHT,
    input  logic [15:0] iCOLOR,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oIF_WR_REQ,
    input  logic        iIF_WR_BUSY,
    output logic [31:0] oIF_WR_ADDR,
    output logic [31:0] oIF_WR_DATA
);

    localparam logic [31:0] LP_H = 32'(P_H_WIDTH);
    localparam logic [31:0] LP_V = 32'(P_V_HEIGHT);

    typedef enum logic [1:0] {
        L_IDLE  = 2'd0,
        L_SETUP = 2'd1,
        L_WRITE = 2'd2,
        L_DONE  = 2'd3
    } state_t;

    state_t      state, stateNext;

    logic [9:0]  xStart;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [10:0] width;
    logic [9:0]  height;
    logic [15:0] color;
    logic [9:0]  xEnd;
    logic [9:0]  yEnd;
    logic [31:0] rowAddr;

    logic [31:0] xSum, ySum, xLim, yLim;
    logic        empty;
    logic        accept;
    logic        lastCol;
    logic        lastPixel;

    // Clip bounds and emptiness, evaluated from the latched rectangle (used in SETUP).
    always_comb begin
        xSum      = 32'(xStart) + 32'(width);
        ySum      = 32'(y) + 32'(height);
        xLim      = (xSum > LP_H) ? LP_H : xSum;
        yLim      = (ySum > LP_V) ? LP_V : ySum;
        empty     = (width == 11'd0) || (height == 10'd0) ||
                    (32'(xStart) >= LP_H) || (32'(y) >= LP_V);
        accept    = (state == L_WRITE) && !iIF_WR_BUSY;
        lastCol   = (x == xEnd);
        lastPixel = lastCol && (y == yEnd);
    end

    // State register.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) state <= L_IDLE;
        else          state <= stateNext;
    end

    // Next-state and outputs; the sync abort overrides everything.
    always_comb begin
        stateNext   = state;
        oBUSY       = (state != L_IDLE);
        oDONE       = (state == L_DONE);
        oIF_WR_REQ  = (state == L_WRITE);
        oIF_WR_ADDR = 32'h0;
        oIF_WR_DATA = 32'h0;
        case (state)
            L_IDLE:  if (iSTART) stateNext = L_SETUP;
            L_SETUP: stateNext = empty ? L_DONE : L_WRITE;
            L_WRITE: if (accept && lastPixel) stateNext = L_DONE;
            L_DONE:  stateNext = L_IDLE;
            default: stateNext = L_IDLE;
        endcase
        if (iRESET_SYNC) stateNext = L_IDLE;
        if (state == L_WRITE) begin
            oIF_WR_ADDR = rowAddr + 32'(x);
            oIF_WR_DATA = {16'h0, color};
        end
    end

    // Rectangle latch, clip setup and scan cursor.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            xStart  <= '0;
            x       <= '0;
            y       <= '0;
            width   <= '0;
            height  <= '0;
            color   <= '0;
            xEnd    <= '0;
            yEnd    <= '0;
            rowAddr <= '0;
        end else if (!iRESET_SYNC) begin
            case (state)
                L_IDLE: if (iSTART) begin
                    xStart <= iX;
                    x      <= iX;
                    y      <= iY;
                    width  <= iWIDTH;
                    height <= iHEIGHT;
                    color  <= iCOLOR;
                end
                L_SETUP: begin
                    // Values are meaningless for an empty rectangle; it never reaches WRITE.
                    xEnd    <= 10'(xLim - 32'd1);
                    yEnd    <= 10'(yLim - 32'd1);
                    rowAddr <= P_ADDR_BASE + 32'(y) * LP_H;
                end
                L_WRITE: if (accept) begin
                    if (lastCol) begin
                        if (!lastPixel) begin
                            x       <= xStart;
                            y       <= y + 10'd1;
                            rowAddr <= rowAddr + LP_H;
                        end
                    end else begin
                        x <= x + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gci_std_display_fill_engine.sv
// Bench for the rectangle fill engine: reset values, directed vectors,
// handshake corner cases and randomized fills against a pixel-list model.
module tb_gci_std_display_fill_engine;

    logic        iCLOCK, inRESET, iRESET_SYNC, iSTART;
    logic [9:0]  iX, iY, iHEIGHT;
    logic [10:0] iWIDTH;
    logic [15:0] iCOLOR;
    logic        oBUSY, oDONE, oIF_WR_REQ, iIF_WR_BUSY;
    logic [31:0] oIF_WR_ADDR, oIF_WR_DATA;

    gci_std_display_fill_engine dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .iSTART(iSTART),
        .iX(iX), .iY(iY), .iWIDTH(iWIDTH), .iHEIGHT(iHEIGHT), .iCOLOR(iCOLOR),
        .oBUSY(oBUSY), .oDONE(oDONE), .oIF_WR_REQ(oIF_WR_REQ), .iIF_WR_BUSY(iIF_WR_BUSY),
        .oIF_WR_ADDR(oIF_WR_ADDR), .oIF_WR_DATA(oIF_WR_DATA)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    logic [31:0] capA[$];
    logic [31:0] capD[$];
    logic        prevHold = 1'b0;
    logic [31:0] prevAddr, prevData;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    // Observe the interface mid-cycle: record accepted writes, DONE pulses and hold stability.
    always @(negedge iCLOCK) begin
        if (prevHold && inRESET) begin
            chk("hold_req", 32'(oIF_WR_REQ), 32'd1);
            chk("hold_addr", oIF_WR_ADDR, prevAddr);
            chk("hold_data", oIF_WR_DATA, prevData);
        end
        prevHold = oIF_WR_REQ && iIF_WR_BUSY && !iRESET_SYNC && inRESET;
        prevAddr = oIF_WR_ADDR;
        prevData = oIF_WR_DATA;
        if (oIF_WR_REQ && !iIF_WR_BUSY && inRESET) begin
            capA.push_back(oIF_WR_ADDR);
            capD.push_back(oIF_WR_DATA);
        end
        if (oDONE) doneCount++;
    end

    // Run one fill to completion and compare the accepted writes with the clipped pixel list.
    task automatic run_fill(input int x, input int y, input int w, input int h,
                            input logic [15:0] c, input int busyPct, input bit pokeStart,
                            output int doneCyc);
        logic [31:0] expQ[$];
        int cyc, dones, n;
        expQ.delete();
        for (int yy = y; yy < y + h && yy < 480; yy++)
            for (int xx = x; xx < x + w && xx < 640; xx++)
                expQ.push_back(32'(640 * yy + xx));
        capA.delete();
        capD.delete();
        iX = 10'(x); iY = 10'(y); iWIDTH = 11'(w); iHEIGHT = 10'(h); iCOLOR = c;
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        cyc = 0;
        dones = 0;
        while (dones == 0 && cyc < 20000) begin
            iIF_WR_BUSY = (busyPct > 0) && ($urandom_range(99) < busyPct);
            if (pokeStart && cyc == 3 && oBUSY) begin
                iSTART = 1'b1;
                iX = 10'($urandom_range(0, 20)); iY = 10'($urandom_range(0, 20));
                iWIDTH = 11'd3; iHEIGHT = 10'd3; iCOLOR = 16'hDEAD;
            end else begin
                iSTART = 1'b0;
            end
            step();
            cyc++;
            if (oDONE) dones++;
        end
        iSTART = 1'b0;
        iIF_WR_BUSY = 1'b0;
        chk("done_seen", 32'(dones), 32'd1);
        step();
        chk("done_one_cycle", 32'(oDONE), 32'd0);
        chk("idle_after_done", 32'(oBUSY), 32'd0);
        chk("write_count", 32'(capA.size()), 32'(expQ.size()));
        n = (capA.size() < expQ.size()) ? capA.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            chk("write_addr", capA[i], expQ[i]);
            chk("write_data", capD[i], {16'h0, c});
        end
        doneCyc = cyc;
    endtask

    typedef struct {
        int          x, y, w, h;
        logic [15:0] c;
        int          nw;
        logic [31:0] first, last;
    } vec_t;

    vec_t vecs[$];
    int   dc;

    initial begin
        vecs.push_back('{1,   1,   2,    2,    16'hF800, 4,   32'd641,    32'd1282});
        vecs.push_back('{638, 479, 4,    3,    16'h07E0, 2,   32'd307198, 32'd307199});
        vecs.push_back('{5,   5,   0,    3,    16'h1111, 0,   32'd0,      32'd0});
        vecs.push_back('{640, 0,   5,    5,    16'h2222, 0,   32'd0,      32'd0});
        vecs.push_back('{3,   3,   4,    0,    16'h3333, 0,   32'd0,      32'd0});
        vecs.push_back('{0,   480, 4,    4,    16'h4444, 0,   32'd0,      32'd0});
        vecs.push_back('{0,   0,   640,  1,    16'hFFFF, 640, 32'd0,      32'd639});
        vecs.push_back('{600, 10,  2047, 2,    16'h001F, 80,  32'd7000,   32'd7679});
        vecs.push_back('{0,   470, 1,    1023, 16'hABCD, 10,  32'd300800, 32'd306560});

        inRESET = 1'b0; iRESET_SYNC = 1'b0; iSTART = 1'b0; iIF_WR_BUSY = 1'b0;
        iX = '0; iY = '0; iWIDTH = '0; iHEIGHT = '0; iCOLOR = '0;
        #12;
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_req", 32'(oIF_WR_REQ), 32'd0);
        chk("rst_addr", oIF_WR_ADDR, 32'd0);
        chk("rst_data", oIF_WR_DATA, 32'd0);
        inRESET = 1'b1;
        step();

        // Directed vectors with an idle controller: count, ends of the scan, no-bubble latency.
        foreach (vecs[i]) begin
            run_fill(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, 0, 1'b0, dc);
            chk("vec_count", 32'(capA.size()), 32'(vecs[i].nw));
            chk("vec_latency", 32'(dc), 32'(vecs[i].nw + 1));
            if (capA.size() > 0) begin
                chk("vec_first", capA[0], vecs[i].first);
                chk("vec_last", capA[capA.size() - 1], vecs[i].last);
            end
        end

        // Basic fill cycle by cycle: REQ first seen two cycles after iSTART.
        iX = 10'd1; iY = 10'd1; iWIDTH = 11'd2; iHEIGHT = 10'd2; iCOLOR = 16'hF800;
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        chk("t1_setup_req", 32'(oIF_WR_REQ), 32'd0);
        chk("t1_setup_busy", 32'(oBUSY), 32'd1);
        step(); chk("t1_a0", oIF_WR_ADDR, 32'd641); chk("t1_d0", oIF_WR_DATA, 32'h0000F800);
        step(); chk("t1_a1", oIF_WR_ADDR, 32'd642);
        step(); chk("t1_a2", oIF_WR_ADDR, 32'd1281);
        step(); chk("t1_a3", oIF_WR_ADDR, 32'd1282); chk("t1_req3", 32'(oIF_WR_REQ), 32'd1);
        step(); chk("t1_done", 32'(oDONE), 32'd1); chk("t1_req_drop", 32'(oIF_WR_REQ), 32'd0);
        step(); chk("t1_done_clr", 32'(oDONE), 32'd0); chk("t1_idle", 32'(oBUSY), 32'd0);

        // Backpressure on the second pixel for three cycles.
        capA.delete(); capD.delete();
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        step();
        step(); chk("t2_a1", oIF_WR_ADDR, 32'd642);
        iIF_WR_BUSY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_hold_addr", oIF_WR_ADDR, 32'd642);
            chk("t2_hold_req", 32'(oIF_WR_REQ), 32'd1);
        end
        iIF_WR_BUSY = 1'b0;
        step(); chk("t2_a2", oIF_WR_ADDR, 32'd1281);
        step(); chk("t2_a3", oIF_WR_ADDR, 32'd1282);
        step(); chk("t2_done", 32'(oDONE), 32'd1);
        chk("t2_total", 32'(capA.size()), 32'd4);
        step();

        // Sync abort during the second row of a 4x4 fill, then a clean restart.
        iX = 10'd0; iY = 10'd0; iWIDTH = 11'd4; iHEIGHT = 10'd4; iCOLOR = 16'h1234;
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        step();
        repeat (5) step();
        chk("t5_mid_addr", oIF_WR_ADDR, 32'd641);
        dc = doneCount;
        iRESET_SYNC = 1'b1;
        step();
        iRESET_SYNC = 1'b0;
        chk("t5_req", 32'(oIF_WR_REQ), 32'd0);
        chk("t5_done", 32'(oDONE), 32'd0);
        chk("t5_busy", 32'(oBUSY), 32'd0);
        step();
        chk("t5_no_done_pulse", 32'(doneCount), 32'(dc));
        run_fill(0, 0, 4, 4, 16'h1234, 0, 1'b1, dc);

        // Randomized fills with random backpressure and ignored mid-fill starts.
        for (int i = 0; i < 24; i++) begin
            int rx, ry, rw, rh;
            rx = $urandom_range(0, 660);
            ry = $urandom_range(0, 490);
            rw = (i % 6 == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 12);
            rh = $urandom_range(0, 6);
            run_fill(rx, ry, rw, rh, 16'($urandom), 30, (i % 3 == 0), dc);
        end

        // Async reset mid-fill clears every output before the next edge.
        iX = 10'd10; iY = 10'd10; iWIDTH = 11'd8; iHEIGHT = 10'd8; iCOLOR = 16'h5A5A;
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        step(); step();
        chk("t6_pre_req", 32'(oIF_WR_REQ), 32'd1);
        #2 inRESET = 1'b0;
        #1;
        chk("t6_req", 32'(oIF_WR_REQ), 32'd0);
        chk("t6_busy", 32'(oBUSY), 32'd0);
        chk("t6_done", 32'(oDONE), 32'd0);
        chk("t6_addr", oIF_WR_ADDR, 32'd0);
        chk("t6_data", oIF_WR_DATA, 32'd0);
        #1 inRESET = 1'b1;
        step();
        run_fill(7, 9, 3, 2, 16'h0F0F, 0, 1'b0, dc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
